// File: rtl/mem_access_unit.sv
// Load/store initiator for the data memory: handshakes requests from the pipeline, drives
// a combinational-read memory, and does read-modify-write for byte and halfword stores.
module mem_access_unit #(
    parameter int unsigned        AWIDTH    = 32,
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h01000000,
    parameter logic [AWIDTH-1:0]  MEM_BYTES = 32'h00100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [2:0]        req_size_i,
    input  logic              req_store_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [2:0]        mem_size_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr,
        StResp
    } state_e;

    localparam logic [AWIDTH:0] EndAddr = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        size_q;

    logic              req_err;
    logic [AWIDTH:0]   addr_last;
    logic [DWIDTH-1:0] merged;

    // The range check covers a full word from the request address, whatever the size.
    always_comb begin
        addr_last = {1'b0, req_addr_i} + (AWIDTH + 1)'(3);
        req_err   = 1'b0;
        if (req_size_i == 3'd3 || req_size_i == 3'd6 || req_size_i == 3'd7) req_err = 1'b1;
        if (req_store_i && req_size_i[2]) req_err = 1'b1;
        if (req_size_i[1:0] == 2'd1 && req_addr_i[0]) req_err = 1'b1;
        if (req_size_i == 3'd2 && req_addr_i[1:0] != 2'b00) req_err = 1'b1;
        if (req_addr_i < BASE_ADDR || addr_last >= EndAddr) req_err = 1'b1;
    end

    // Only SB (size 0) and SH (size 1) reach the read-modify-write path.
    always_comb begin
        merged = mem_data_i;
        if (!size_q[0]) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: ;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            wdata_q        <= '0;
            size_q         <= '0;
            req_ready_o    <= 1'b1;
            resp_valid_o   <= 1'b0;
            resp_rdata_o   <= '0;
            resp_err_o     <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            mem_size_o     <= '0;
            mem_read_en_o  <= 1'b0;
            mem_write_en_o <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        size_q      <= req_size_i;
                        req_ready_o <= 1'b0;
                        if (req_err) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                            state_q      <= StResp;
                        end else if (!req_store_i) begin
                            mem_read_en_o <= 1'b1;
                            mem_addr_o    <= req_addr_i;
                            mem_size_o    <= req_size_i;
                            state_q       <= StLoad;
                        end else if (req_size_i == 3'd2) begin
                            mem_write_en_o <= 1'b1;
                            mem_addr_o     <= req_addr_i;
                            mem_data_o     <= req_wdata_i;
                            mem_size_o     <= 3'd2;
                            state_q        <= StStore;
                        end else begin
                            mem_read_en_o <= 1'b1;
                            mem_addr_o    <= {req_addr_i[AWIDTH-1:2], 2'b00};
                            mem_size_o    <= 3'd2;
                            state_q       <= StRmwRd;
                        end
                    end
                end
                StLoad: begin
                    mem_read_en_o <= 1'b0;
                    resp_valid_o  <= 1'b1;
                    resp_rdata_o  <= mem_data_i;
                    state_q       <= StResp;
                end
                StStore: begin
                    mem_write_en_o <= 1'b0;
                    resp_valid_o   <= 1'b1;
                    resp_rdata_o   <= '0;
                    state_q        <= StResp;
                end
                StRmwRd: begin
                    mem_read_en_o  <= 1'b0;
                    mem_write_en_o <= 1'b1;
                    mem_data_o     <= merged;
                    state_q        <= StRmwWr;
                end
                StRmwWr: begin
                    mem_write_en_o <= 1'b0;
                    resp_valid_o   <= 1'b1;
                    resp_rdata_o   <= '0;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= '0;
                        req_ready_o  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-addressed memory model.
module tb_mem_access_unit;

    localparam logic [31:0] Base = 32'h01000000;
    localparam logic [31:0] Size = 32'h00100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic        req_store = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .AWIDTH   (32),
        .DWIDTH   (32),
        .BASE_ADDR(Base),
        .MEM_BYTES(Size)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_size_i    (req_size),
        .req_store_i   (req_store),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_size_o    (mem_size),
        .mem_read_en_o (mem_rd),
        .mem_write_en_o(mem_wr),
        .mem_data_i    (mem_rdata)
    );

    // 64-byte window indexed by addr[5:0]; test addresses near base and near the top
    // of the range land on distinct bytes.
    logic [7:0]  mem [64];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_total = 0;

    always_comb begin
        logic [5:0] a;
        logic [31:0] w;
        a = mem_addr[5:0];
        w = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
        case (mem_size)
            3'd0:    mem_rdata = {{24{w[7]}}, w[7:0]};
            3'd1:    mem_rdata = {{16{w[15]}}, w[15:0]};
            3'd4:    mem_rdata = {24'b0, w[7:0]};
            3'd5:    mem_rdata = {16'b0, w[15:0]};
            default: mem_rdata = w;
        endcase
    end

    always @(posedge clk) begin
        logic [31:0] wv;
        if (pl_en) begin
            for (int k = 0; k < 4; k++) mem[pl_addr[5:0] + 6'(k)] <= pl_data[8*k +: 8];
        end else if (mem_wr) begin
            wv = (mem_size == 3'd0) ? {24'b0, mem_wdata[7:0]} :
                 (mem_size == 3'd1) ? {16'b0, mem_wdata[15:0]} : mem_wdata;
            for (int k = 0; k < 4; k++) mem[mem_addr[5:0] + 6'(k)] <= wv[8*k +: 8];
            wr_total <= wr_total + 1;
        end
    end

    function automatic logic [31:0] peek(input logic [31:0] addr);
        logic [5:0] a;
        a = addr[5:0];
        return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its response; latency counts the
    // accept edge as 1.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic store,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int writes);
        int w0;
        @(negedge clk);
        w0        = wr_total;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_store = store;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk);
        #1;
        writes = wr_total - w0;
    endtask

    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;
    int          wrs;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wr_en", 32'(mem_wr), 32'd0);
        check("rst_rd_en", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Byte store by read-modify-write
        preload(32'h01000004, 32'hAABBCCDD);
        preload(32'h01000000, 32'h55667788);
        do_req(32'h01000005, 32'h00000011, 3'd0, 1'b1, rd, er, lat, wrs);
        check("sb_err", 32'(er), 32'd0);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_writes", 32'(wrs), 32'd1);
        check("sb_word", peek(32'h01000004), 32'hAABB11DD);
        check("sb_rdata", rd, 32'd0);

        // Halfword store then loads
        preload(32'h01000004, 32'hAABBCCDD);
        do_req(32'h01000006, 32'h00001234, 3'd1, 1'b1, rd, er, lat, wrs);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_word", peek(32'h01000004), 32'h1234CCDD);
        do_req(32'h01000007, 32'h0, 3'd0, 1'b0, rd, er, lat, wrs);
        check("lb_data", rd, 32'h00000012);
        check("lb_lat", 32'(lat), 32'd2);
        do_req(32'h01000006, 32'h0, 3'd5, 1'b0, rd, er, lat, wrs);
        check("lhu_data", rd, 32'h00001234);
        do_req(32'h01000005, 32'h0, 3'd0, 1'b0, rd, er, lat, wrs);
        check("lb_sext", rd, 32'hFFFFFFCC);
        do_req(32'h01000004, 32'h0, 3'd2, 1'b0, rd, er, lat, wrs);
        check("lw_data", rd, 32'h1234CCDD);

        // Misaligned requests
        do_req(32'h01000001, 32'h0, 3'd1, 1'b0, rd, er, lat, wrs);
        check("lh_mis_err", 32'(er), 32'd1);
        check("lh_mis_lat", 32'(lat), 32'd1);
        do_req(32'h01000002, 32'hDEADBEEF, 3'd2, 1'b1, rd, er, lat, wrs);
        check("sw_mis_err", 32'(er), 32'd1);
        check("sw_mis_lat", 32'(lat), 32'd1);
        check("sw_mis_writes", 32'(wrs), 32'd0);
        check("sw_mis_mem", peek(32'h01000000), 32'h55667788);

        // Range and size errors
        do_req(32'h00FFFFFC, 32'h0, 3'd2, 1'b0, rd, er, lat, wrs);
        check("lw_below_err", 32'(er), 32'd1);
        do_req(Base + Size - 32'd2, 32'h0, 3'd1, 1'b1, rd, er, lat, wrs);
        check("sh_top_err", 32'(er), 32'd1);
        do_req(Base + Size - 32'd2, 32'h0, 3'd2, 1'b1, rd, er, lat, wrs);
        check("sw_top_err", 32'(er), 32'd1);
        do_req(32'h01000004, 32'h0, 3'd4, 1'b1, rd, er, lat, wrs);
        check("st_size4_err", 32'(er), 32'd1);
        check("st_size4_writes", 32'(wrs), 32'd0);
        do_req(32'h01000004, 32'h0, 3'd3, 1'b0, rd, er, lat, wrs);
        check("ld_size3_err", 32'(er), 32'd1);
        check("ld_size3_rdata", rd, 32'd0);
        preload(Base + Size - 32'd4, 32'hCAFEF00D);
        do_req(Base + Size - 32'd4, 32'h0, 3'd2, 1'b0, rd, er, lat, wrs);
        check("lw_top_err", 32'(er), 32'd0);
        check("lw_top_data", rd, 32'hCAFEF00D);
        do_req(Base + Size - 32'd4, 32'h0BADBEEF, 3'd2, 1'b1, rd, er, lat, wrs);
        check("sw_top_lat", 32'(lat), 32'd2);
        check("sw_top_writes", 32'(wrs), 32'd1);
        check("sw_top_mem", peek(Base + Size - 32'd4), 32'h0BADBEEF);

        // Response back-pressure
        @(negedge clk);
        resp_ready = 1'b0;
        req_addr   = 32'h01000004;
        req_size   = 3'd2;
        req_store  = 1'b0;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        held = resp_rdata;
        check("bp_first", held, 32'h1234CCDD);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'h1234CCDD);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        do_req(Base + Size - 32'd4, 32'h0, 3'd2, 1'b0, rd, er, lat, wrs);
        check("bp_resume", rd, 32'h0BADBEEF);

        // Reset while the merged word is being written
        preload(32'h01000008, 32'h01020304);
        @(negedge clk);
        wrs       = wr_total;
        req_addr  = 32'h01000008;
        req_wdata = 32'h000000FF;
        req_size  = 3'd0;
        req_store = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_wr_en", 32'(mem_wr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wr_en", 32'(mem_wr), 32'd0);
        check("arst_rd_en", 32'(mem_rd), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_valid", 32'(resp_valid), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_data", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        check("arst_mem", peek(32'h01000008), 32'h01020304);
        check("arst_writes", 32'(wr_total - wrs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_req(32'h01000008, 32'h0, 3'd2, 1'b0, rd, er, lat, wrs);
        check("arst_after", rd, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
